// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 8-stage amber pipeline (IA IF XT ID EX MA MO WB).
// Combines memory back-pressure, load-use, branch redirects and halt/resume into per-stage vectors.
module pipe_ctrl #(
  parameter int REDIRECT_CYC = 1,
  parameter int DRAIN_CYC    = 7,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16,
  parameter int HBIT_ADDR    = 31
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic                 iw_mem_busy,
  input  logic                 iw_ld_use,
  input  logic                 iw_br_taken,
  input  logic [HBIT_ADDR:0]   iw_br_pc,
  input  logic                 iw_xt_busy,
  input  logic                 iw_halt_req,
  input  logic                 iw_resume,
  output logic [7:0]           ow_stall,
  output logic [7:0]           ow_flush,
  output logic                 ow_redirect,
  output logic [HBIT_ADDR:0]   ow_redirect_pc,
  output logic                 ow_halted,
  output logic                 ow_timeout,
  output logic [CNT_W-1:0]     ow_stall_cycles
);

  typedef enum logic [1:0] {RUN, REDIR, DRAIN, HALT} state_t;

  localparam int SEQ_MAX = (REDIRECT_CYC > DRAIN_CYC) ? REDIRECT_CYC : DRAIN_CYC;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int BUSY_W  = $clog2(MEM_TIMEOUT + 1);

  state_t               state, state_nx;
  logic [SEQ_W-1:0]     cnt, cnt_nx;
  logic [BUSY_W-1:0]    busy_cnt;
  logic [HBIT_ADDR:0]   last_pc;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ow_stall    = '0;
    ow_flush    = '0;
    ow_redirect = 1'b0;

    if (iw_rst) begin
      ow_flush = 8'hFF;
    end else if (iw_mem_busy) begin
      // MA cannot retire: freeze everything up to MA and bubble MO; state is held too.
      ow_stall = 8'h3F;
      ow_flush = 8'h40;
    end else if (iw_br_taken) begin
      ow_flush    = 8'h0F;
      ow_redirect = 1'b1;
      cnt_nx      = '0;
      // A branch during a drain/halt redirects but keeps the halt sequence alive.
      if (state == RUN || state == REDIR)
        state_nx = (REDIRECT_CYC > 1) ? REDIR : RUN;
    end else if (iw_ld_use) begin
      ow_stall = 8'h0F;
      ow_flush = 8'h10;
    end else begin
      case (state)
        RUN: begin
          // Wait for XT to finish its macro expansion so micro-op sequences stay whole.
          if (iw_halt_req && !iw_xt_busy) begin
            state_nx = DRAIN;
            cnt_nx   = '0;
          end
        end
        REDIR: begin
          ow_flush = 8'h0F;
          if (32'(cnt) == REDIRECT_CYC - 2) state_nx = RUN;
          else                              cnt_nx   = cnt + 1'b1;
        end
        DRAIN: begin
          ow_stall = 8'h01;
          ow_flush = 8'h02;
          if (!iw_halt_req)                        state_nx = RUN;
          else if (32'(cnt) == DRAIN_CYC - 1)      state_nx = HALT;
          else                                     cnt_nx   = cnt + 1'b1;
        end
        HALT: begin
          ow_stall = 8'h01;
          ow_flush = 8'h02;
          if (iw_resume) state_nx = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign ow_halted      = (state == HALT) && !iw_rst;
  assign ow_redirect_pc = iw_rst ? '0 : (ow_redirect ? iw_br_pc : last_pc);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state           <= RUN;
      cnt             <= '0;
      busy_cnt        <= '0;
      last_pc         <= '0;
      ow_timeout      <= 1'b0;
      ow_stall_cycles <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ow_redirect) last_pc <= iw_br_pc;

      if (iw_mem_busy) begin
        if (32'(busy_cnt) + 1 >= MEM_TIMEOUT) ow_timeout <= 1'b1;
        if (32'(busy_cnt) < MEM_TIMEOUT)      busy_cnt   <= busy_cnt + 1'b1;
      end else begin
        busy_cnt <= '0;
      end

      if (|ow_stall && ow_stall_cycles != '1)
        ow_stall_cycles <= ow_stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the single-cycle priority
// cases, then hand sequences for branch-under-busy, halt/drain and timeout.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, mem_busy, ld_use, br_taken, xt_busy, halt_req, resume;
  logic [15:0] br_pc;
  logic [7:0]  stall, flush;
  logic        redirect, halted, timeout;
  logic [15:0] redirect_pc;
  logic [15:0] stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .REDIRECT_CYC(1), .DRAIN_CYC(7), .MEM_TIMEOUT(4), .CNT_W(16), .HBIT_ADDR(15)
  ) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_mem_busy(mem_busy), .iw_ld_use(ld_use),
    .iw_br_taken(br_taken), .iw_br_pc(br_pc), .iw_xt_busy(xt_busy),
    .iw_halt_req(halt_req), .iw_resume(resume),
    .ow_stall(stall), .ow_flush(flush), .ow_redirect(redirect),
    .ow_redirect_pc(redirect_pc), .ow_halted(halted), .ow_timeout(timeout),
    .ow_stall_cycles(stall_cycles)
  );

  typedef struct {
    logic        busy, ld, br;
    logic [15:0] pc;
    logic [7:0]  es, ef;
    logic        er;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  // Checks combinational outputs for the current inputs, then advances one clock.
  task automatic cyc(input string name, input logic [7:0] es, input logic [7:0] ef,
                     input logic er, input logic [15:0] epc, input logic eh);
    #1;
    check({name, ".stall"}, 32'(stall), 32'(es));
    check({name, ".flush"}, 32'(flush), 32'(ef));
    check({name, ".redir"}, 32'(redirect), 32'(er));
    check({name, ".halted"}, 32'(halted), 32'(eh));
    if (er) check({name, ".pc"}, 32'(redirect_pc), 32'(epc));
    if (es != 8'h00) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_busy = 0; ld_use = 0; br_taken = 0; br_pc = '0;
    xt_busy = 0; halt_req = 0; resume = 0;

    vecs[0] = '{0, 0, 0, 16'h0000, 8'h00, 8'h00, 0};
    vecs[1] = '{0, 0, 1, 16'h1234, 8'h00, 8'h0F, 1};
    vecs[2] = '{0, 0, 0, 16'h0000, 8'h00, 8'h00, 0};
    vecs[3] = '{0, 1, 0, 16'h0000, 8'h0F, 8'h10, 0};
    vecs[4] = '{0, 1, 1, 16'h55AA, 8'h00, 8'h0F, 1};
    vecs[5] = '{1, 0, 0, 16'h0000, 8'h3F, 8'h40, 0};
    vecs[6] = '{1, 1, 1, 16'h7777, 8'h3F, 8'h40, 0};
    vecs[7] = '{1, 1, 0, 16'h0000, 8'h3F, 8'h40, 0};
    vecs[8] = '{0, 0, 0, 16'h0000, 8'h00, 8'h00, 0};

    // Reset held two cycles: flush everything, stall nothing.
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check("rst.flush", 32'(flush), 32'hFF);
      check("rst.stall", 32'(stall), 32'h00);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("post_rst.flush", 32'(flush), 32'h00);
    check("post_rst.halted", 32'(halted), 32'h0);
    check("post_rst.sc", 32'(stall_cycles), 32'h0);
    check("post_rst.timeout", 32'(timeout), 32'h0);

    // Single-cycle priority table.
    for (int i = 0; i < 9; i++) begin
      mem_busy = vecs[i].busy; ld_use = vecs[i].ld; br_taken = vecs[i].br; br_pc = vecs[i].pc;
      cyc($sformatf("vec%0d", i), vecs[i].es, vecs[i].ef, vecs[i].er, vecs[i].pc, 1'b0);
    end
    check("vec.sc", 32'(stall_cycles), 32'(exp_sc));

    // Branch held in EX through three busy cycles, taken on the first free cycle.
    mem_busy = 1; br_taken = 1; br_pc = 16'hABCD;
    for (int i = 0; i < 3; i++) cyc("busy_br", 8'h3F, 8'h40, 1'b0, 16'h0, 1'b0);
    mem_busy = 0;
    cyc("br_after_busy", 8'h00, 8'h0F, 1'b1, 16'hABCD, 1'b0);
    br_taken = 0;
    cyc("br_done", 8'h00, 8'h00, 1'b0, 16'h0, 1'b0);
    check("busy_br.sc", 32'(stall_cycles), 32'(exp_sc));

    // Halt deferred while XT is mid-expansion, then drain for 7 cycles into HALT.
    halt_req = 1; xt_busy = 1;
    for (int i = 0; i < 3; i++) cyc("halt_xt", 8'h00, 8'h00, 1'b0, 16'h0, 1'b0);
    xt_busy = 0;
    cyc("halt_go", 8'h00, 8'h00, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 7; i++) cyc("drain", 8'h01, 8'h02, 1'b0, 16'h0, 1'b0);
    cyc("halt0", 8'h01, 8'h02, 1'b0, 16'h0, 1'b1);
    cyc("halt1", 8'h01, 8'h02, 1'b0, 16'h0, 1'b1);
    resume = 1; halt_req = 0;
    cyc("resume", 8'h01, 8'h02, 1'b0, 16'h0, 1'b1);
    resume = 0;
    cyc("resumed", 8'h00, 8'h00, 1'b0, 16'h0, 1'b0);

    // Branch during DRAIN redirects and restarts the 7-cycle drain count.
    halt_req = 1;
    cyc("halt2_go", 8'h00, 8'h00, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("drain_pre", 8'h01, 8'h02, 1'b0, 16'h0, 1'b0);
    br_taken = 1; br_pc = 16'h0BAD;
    cyc("drain_br", 8'h00, 8'h0F, 1'b1, 16'h0BAD, 1'b0);
    br_taken = 0;
    for (int i = 0; i < 7; i++) cyc("drain_post", 8'h01, 8'h02, 1'b0, 16'h0, 1'b0);
    cyc("halt_after_br", 8'h01, 8'h02, 1'b0, 16'h0, 1'b1);
    resume = 1; halt_req = 0;
    cyc("resume2", 8'h01, 8'h02, 1'b0, 16'h0, 1'b1);
    resume = 0;

    // Dropping halt_req mid-drain returns to RUN.
    halt_req = 1;
    cyc("halt3_go", 8'h00, 8'h00, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("drain3", 8'h01, 8'h02, 1'b0, 16'h0, 1'b0);
    halt_req = 0;
    cyc("drain_abort", 8'h01, 8'h02, 1'b0, 16'h0, 1'b0);
    cyc("run_again", 8'h00, 8'h00, 1'b0, 16'h0, 1'b0);
    check("halt.sc", 32'(stall_cycles), 32'(exp_sc));

    // Timeout: set after the 4th consecutive busy cycle, sticky until reset.
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tmo_busy%0d", i), 32'(timeout), 32'h0);
      cyc("tmo_busy", 8'h3F, 8'h40, 1'b0, 16'h0, 1'b0);
    end
    mem_busy = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tmo_sticky%0d", i), 32'(timeout), 32'h1);
      cyc("tmo_idle", 8'h00, 8'h00, 1'b0, 16'h0, 1'b0);
    end
    check("tmo.sc", 32'(stall_cycles), 32'(exp_sc));

    rst = 1;
    #1;
    check("rst2.flush", 32'(flush), 32'hFF);
    check("rst2.stall", 32'(stall), 32'h00);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("rst2.timeout", 32'(timeout), 32'h0);
    check("rst2.sc", 32'(stall_cycles), 32'h0);
    check("rst2.flush_rel", 32'(flush), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
